// File: rtl/fp_unidade_controle.sv
// fp_unidade_controle: Moore FSM sequencing align, operate, normalize and round on the FP datapath.
module fp_unidade_controle #(
  parameter int LARGURA_FRAC = 26,
  parameter int MAX_SHIFT    = 26,
  parameter int MAX_NORM     = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] diff_expoente,
  input  logic       a_menor,
  input  logic       ula_overflow,
  input  logic       msb_resultado,
  input  logic       resultado_zero,
  input  logic [7:0] expoente,
  input  logic       arred_overflow,
  output logic       soma_multiplica,
  output logic       decisor_mux_expoentes,
  output logic       decisor_mux_expoente_escolhido,
  output logic       decisor_mux_escolhe_shift_right,
  output logic       decisor_mux_entrada_dois_ula,
  output logic       decisor_mux_saida_big_ula,
  output logic       decisor_shift_right_left,
  output logic [4:0] tamanho,
  output logic [4:0] tamanho2,
  output logic       subtrador_Somador_subtrador,
  output logic       carga_expoente,
  output logic       carga_fracao,
  output logic       busy,
  output logic       done,
  output logic       excecao
);
  localparam int LIM = (MAX_SHIFT < LARGURA_FRAC) ? MAX_SHIFT : LARGURA_FRAC;
  localparam int CW  = $clog2(MAX_NORM + 1);
  typedef enum logic [2:0] {IDLE, ALINHA, OPERA, NORMALIZA, ARREDONDA, REAJUSTE, FIM} estado_t;
  estado_t       estado;
  logic          op_reg;
  logic [CW-1:0] contador;
  logic [CW-1:0] contador_base;
  logic          passo_esq;
  logic          desloca_esq;
  logic          entra_norm;
  logic [4:0]    alinhamento;
  assign alinhamento   = (diff_expoente > 8'(LIM)) ? 5'(LIM) : diff_expoente[4:0];
  assign contador_base = (estado == OPERA) ? '0 : contador;
  // a left step was issued this cycle, so normalization must be re-evaluated
  assign passo_esq     = decisor_shift_right_left && carga_fracao;
  assign desloca_esq   = !ula_overflow && !msb_resultado && contador_base < CW'(MAX_NORM) && expoente > 8'd1;
  assign entra_norm    = (estado == OPERA && !resultado_zero) || (estado == NORMALIZA && passo_esq);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado                          <= IDLE;
      op_reg                          <= 1'b0;
      contador                        <= '0;
      soma_multiplica                 <= 1'b0;
      decisor_mux_expoentes           <= 1'b0;
      decisor_mux_expoente_escolhido  <= 1'b0;
      decisor_mux_escolhe_shift_right <= 1'b0;
      decisor_mux_entrada_dois_ula    <= 1'b0;
      decisor_mux_saida_big_ula       <= 1'b0;
      decisor_shift_right_left        <= 1'b0;
      tamanho                         <= '0;
      tamanho2                        <= '0;
      subtrador_Somador_subtrador     <= 1'b0;
      carga_expoente                  <= 1'b0;
      carga_fracao                    <= 1'b0;
      busy                            <= 1'b0;
      done                            <= 1'b0;
      excecao                         <= 1'b0;
    end else begin
      soma_multiplica                 <= 1'b0;
      decisor_mux_expoentes           <= 1'b0;
      decisor_mux_expoente_escolhido  <= 1'b0;
      decisor_mux_escolhe_shift_right <= 1'b0;
      decisor_mux_entrada_dois_ula    <= 1'b0;
      decisor_mux_saida_big_ula       <= 1'b0;
      decisor_shift_right_left        <= 1'b0;
      tamanho                         <= '0;
      tamanho2                        <= '0;
      subtrador_Somador_subtrador     <= 1'b0;
      carga_expoente                  <= 1'b0;
      carga_fracao                    <= 1'b0;
      busy                            <= 1'b0;
      done                            <= 1'b0;
      case (estado)
        IDLE: if (start) begin
          estado                          <= ALINHA;
          op_reg                          <= op;
          busy                            <= 1'b1;
          excecao                         <= 1'b0;
          decisor_mux_expoentes           <= a_menor;
          decisor_mux_escolhe_shift_right <= a_menor;
          decisor_mux_entrada_dois_ula    <= a_menor;
          tamanho                         <= op ? 5'd0 : alinhamento;
          carga_expoente                  <= 1'b1;
        end
        ALINHA: begin
          estado          <= OPERA;
          busy            <= 1'b1;
          soma_multiplica <= ~op_reg;
          carga_fracao    <= 1'b1;
        end
        OPERA, NORMALIZA: if (entra_norm) begin
          estado                         <= NORMALIZA;
          busy                           <= 1'b1;
          decisor_mux_saida_big_ula      <= 1'b1;
          decisor_mux_expoente_escolhido <= 1'b1;
          contador                       <= contador_base + CW'(desloca_esq);
          if (ula_overflow) begin
            tamanho2       <= 5'd1;
            carga_expoente <= 1'b1;
            carga_fracao   <= 1'b1;
            excecao        <= excecao | (expoente == 8'd254);
          end else if (desloca_esq) begin
            decisor_shift_right_left    <= 1'b1;
            subtrador_Somador_subtrador <= 1'b1;
            tamanho2                    <= 5'd1;
            carga_expoente              <= 1'b1;
            carga_fracao                <= 1'b1;
          end else begin
            excecao <= excecao | (!msb_resultado && expoente == 8'd1);
          end
        end else if (estado == OPERA) begin
          estado <= FIM;
          done   <= 1'b1;
        end else begin
          estado <= ARREDONDA;
          busy   <= 1'b1;
        end
        ARREDONDA: if (arred_overflow) begin
          estado                         <= REAJUSTE;
          busy                           <= 1'b1;
          decisor_mux_saida_big_ula      <= 1'b1;
          decisor_mux_expoente_escolhido <= 1'b1;
          tamanho2                       <= 5'd1;
          carga_expoente                 <= 1'b1;
          carga_fracao                   <= 1'b1;
          excecao                        <= excecao | (expoente == 8'd254);
        end else begin
          estado <= FIM;
          done   <= 1'b1;
        end
        REAJUSTE: begin
          estado <= FIM;
          done   <= 1'b1;
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_unidade_controle.sv
// tb_fp_unidade_controle: directed cycle-accurate checks of the FP control FSM.
module tb_fp_unidade_controle;
  logic       clk = 1'b0;
  logic       rst_n, start, op, a_menor, ula_overflow, msb_resultado, resultado_zero, arred_overflow;
  logic [7:0] diff_expoente, expoente;
  logic       soma_multiplica, decisor_mux_expoentes, decisor_mux_expoente_escolhido;
  logic       decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula, decisor_mux_saida_big_ula;
  logic       decisor_shift_right_left, subtrador_Somador_subtrador, carga_expoente, carga_fracao;
  logic       busy, done, excecao;
  logic [4:0] tamanho, tamanho2;
  logic [22:0] saidas;
  int n_chk = 0, n_fail = 0;

  fp_unidade_controle dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .diff_expoente(diff_expoente),
    .a_menor(a_menor), .ula_overflow(ula_overflow), .msb_resultado(msb_resultado),
    .resultado_zero(resultado_zero), .expoente(expoente), .arred_overflow(arred_overflow),
    .soma_multiplica(soma_multiplica), .decisor_mux_expoentes(decisor_mux_expoentes),
    .decisor_mux_expoente_escolhido(decisor_mux_expoente_escolhido),
    .decisor_mux_escolhe_shift_right(decisor_mux_escolhe_shift_right),
    .decisor_mux_entrada_dois_ula(decisor_mux_entrada_dois_ula),
    .decisor_mux_saida_big_ula(decisor_mux_saida_big_ula),
    .decisor_shift_right_left(decisor_shift_right_left), .tamanho(tamanho), .tamanho2(tamanho2),
    .subtrador_Somador_subtrador(subtrador_Somador_subtrador), .carga_expoente(carga_expoente),
    .carga_fracao(carga_fracao), .busy(busy), .done(done), .excecao(excecao)
  );

  always #5 clk = ~clk;
  assign saidas = {soma_multiplica, decisor_mux_expoentes, decisor_mux_expoente_escolhido,
                   decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula, decisor_mux_saida_big_ula,
                   decisor_shift_right_left, tamanho, tamanho2, subtrador_Somador_subtrador,
                   carga_expoente, carga_fracao, busy, done, excecao};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic defaults;
    start = 0; op = 0; diff_expoente = 0; a_menor = 0; ula_overflow = 0; msb_resultado = 1;
    resultado_zero = 0; expoente = 8'd100; arred_overflow = 0;
  endtask

  // issue a request at the end of cycle 0; returns in cycle 1
  task automatic go(input logic o);
    start = 1; op = o;
    step();
    start = 0;
  endtask

  // scans forward from cycle 'from' for the done pulse, bounded
  task automatic run_to_done(input int from, output int at);
    at = -1;
    for (int c = from; c < 60; c++) begin
      if (done === 1'b1) begin at = c; break; end
      step();
    end
  endtask

  task automatic test_reset;
    rst_n = 0; defaults();
    step(); step();
    n_chk++; if (saidas !== 23'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", saidas); end
    rst_n = 1;
    step();
    n_chk++; if (saidas !== 23'd0) begin n_fail++; $display("FAIL reset_idle got=%h exp=0", saidas); end
  endtask

  task automatic test_add;
    int at;
    defaults(); diff_expoente = 8'd3; a_menor = 1;
    go(1'b0);
    n_chk++; if (tamanho !== 5'd3) begin n_fail++; $display("FAIL add_tamanho got=%0d exp=3", tamanho); end
    n_chk++; if ({decisor_mux_expoentes, decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula, carga_expoente, busy} !== 5'b11111)
      begin n_fail++; $display("FAIL add_alinha_sel got=%b exp=11111", {decisor_mux_expoentes, decisor_mux_escolhe_shift_right, decisor_mux_entrada_dois_ula, carga_expoente, busy}); end
    step();
    n_chk++; if ({soma_multiplica, carga_fracao, decisor_mux_saida_big_ula} !== 3'b110)
      begin n_fail++; $display("FAIL add_opera got=%b exp=110", {soma_multiplica, carga_fracao, decisor_mux_saida_big_ula}); end
    run_to_done(2, at);
    n_chk++; if (at != 5) begin n_fail++; $display("FAIL add_latency got=%0d exp=5", at); end
    n_chk++; if ({busy, excecao} !== 2'b00) begin n_fail++; $display("FAIL add_fim got=%b exp=00", {busy, excecao}); end
    step();
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_clamp;
    logic [7:0] d [3] = '{8'd40, 8'd26, 8'd25};
    logic [4:0] e [3] = '{5'd26, 5'd26, 5'd25};
    int at;
    for (int i = 0; i < 3; i++) begin
      defaults(); diff_expoente = d[i];
      go(1'b0);
      n_chk++; if (tamanho !== e[i]) begin n_fail++; $display("FAIL clamp_%0d got=%0d exp=%0d", d[i], tamanho, e[i]); end
      run_to_done(1, at);
      n_chk++; if (at != 5) begin n_fail++; $display("FAIL clamp_latency_%0d got=%0d exp=5", d[i], at); end
      step();
    end
  endtask

  task automatic test_left_norm;
    int at;
    defaults(); msb_resultado = 0;
    go(1'b0);
    step();
    for (int c = 3; c <= 6; c++) begin
      step();
      n_chk++; if ({decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao} !== 9'b1_1_00001_1_1)
        begin n_fail++; $display("FAIL left_step_c%0d got=%b exp=110000111", c, {decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao}); end
      if (c == 6) msb_resultado = 1;
    end
    step();
    n_chk++; if ({decisor_shift_right_left, carga_fracao, busy} !== 3'b001)
      begin n_fail++; $display("FAIL left_exit got=%b exp=001", {decisor_shift_right_left, carga_fracao, busy}); end
    run_to_done(7, at);
    n_chk++; if (at != 9) begin n_fail++; $display("FAIL left_latency got=%0d exp=9", at); end
    step();
    defaults(); msb_resultado = 0; expoente = 8'd1;
    go(1'b0);
    run_to_done(1, at);
    n_chk++; if (at != 5) begin n_fail++; $display("FAIL underflow_latency got=%0d exp=5", at); end
    n_chk++; if (excecao !== 1'b1) begin n_fail++; $display("FAIL underflow_excecao got=%b exp=1", excecao); end
    step();
  endtask

  task automatic test_overflow;
    int at;
    defaults(); ula_overflow = 1; expoente = 8'd254;
    go(1'b0);
    step(); step();
    n_chk++; if ({decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao, excecao} !== 10'b0_0_00001_1_1_1)
      begin n_fail++; $display("FAIL ovf_norm got=%b exp=0000001111", {decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao, excecao}); end
    run_to_done(3, at);
    n_chk++; if (at != 5) begin n_fail++; $display("FAIL ovf_latency got=%0d exp=5", at); end
    n_chk++; if (excecao !== 1'b1) begin n_fail++; $display("FAIL ovf_excecao got=%b exp=1", excecao); end
    step();
    defaults(); arred_overflow = 1;
    go(1'b0);
    n_chk++; if (excecao !== 1'b0) begin n_fail++; $display("FAIL excecao_clear got=%b exp=0", excecao); end
    step(); step(); step(); step();
    n_chk++; if ({decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao, done} !== 10'b0_0_00001_1_1_0)
      begin n_fail++; $display("FAIL reajuste got=%b exp=0000001110", {decisor_shift_right_left, subtrador_Somador_subtrador, tamanho2, carga_expoente, carga_fracao, done}); end
    run_to_done(5, at);
    n_chk++; if (at != 6) begin n_fail++; $display("FAIL reajuste_latency got=%0d exp=6", at); end
    step();
  endtask

  task automatic test_back_to_back;
    int n_done = 0;
    defaults(); resultado_zero = 1; diff_expoente = 8'd10; start = 1; op = 1;
    step();
    n_chk++; if ({tamanho, carga_expoente} !== 6'b00000_1) begin n_fail++; $display("FAIL mul_tamanho got=%b exp=000001", {tamanho, carga_expoente}); end
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        n_chk++; if ({soma_multiplica, carga_fracao} !== 2'b01) begin n_fail++; $display("FAIL mul_opera got=%b exp=01", {soma_multiplica, carga_fracao}); end
      end
      if (c == 3) begin
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_zero_latency done=%b exp=1", done); end
      end
      if (c == 4) begin
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fim_start_ignored busy=%b exp=0", busy); end
        start = 0;
      end
      if (done === 1'b1) n_done++;
      step();
    end
    n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL single_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_reset_midop;
    int n_done = 0;
    defaults(); msb_resultado = 0;
    go(1'b0);
    step(); step();
    rst_n = 0;
    step();
    n_chk++; if (saidas !== 23'd0) begin n_fail++; $display("FAIL midop_reset got=%h exp=0", saidas); end
    step();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) n_done++;
      step();
    end
    n_chk++; if (n_done != 0) begin n_fail++; $display("FAIL midop_no_done got=%0d exp=0", n_done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_clamp();
    test_left_norm();
    test_overflow();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
